// File: rtl/sprite_line_writer.sv
// Sprite row-segment writer for the scanline buffer: read-modify-write of 4 pixels,
// transparent skip, first-drawn-wins priority and a sticky collision flag.
module sprite_line_writer #(
    parameter int unsigned XW   = 10,
    parameter int unsigned COLW = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seg_valid,
    output logic              seg_ready,
    input  logic [XW-1:0]     seg_x,
    input  logic [15:0]       seg_pix,
    input  logic [COLW-1:0]   seg_col,
    input  logic              seg_flip,
    output logic [XW-1:0]     lb_wadr,
    output logic [COLW+3:0]   lb_wdat,
    output logic              lb_we,
    input  logic [COLW+3:0]   lb_rdat1,
    input  logic              coll_clr,
    output logic              coll_flag
);

    localparam int unsigned DW = COLW + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t            r_state;
    logic [XW-1:0]     r_x;
    logic [15:0]       r_pix;
    logic [COLW-1:0]   r_col;
    logic              r_flip;
    logic [1:0]        r_k;
    logic              r_coll;

    logic [1:0]        w_sel;
    logic [3:0]        w_nib;
    logic              w_last;
    logic              w_slot_free;
    logic              w_unused;

    // Unflipped segments draw the most significant nibble first.
    assign w_sel       = r_flip ? r_k : (2'd3 - r_k);
    assign w_nib       = r_pix[{w_sel, 2'b00} +: 4];
    assign w_last      = (r_k == 2'd3);
    assign w_slot_free = (lb_rdat1[3:0] == 4'd0);
    assign w_unused    = ^lb_rdat1[DW-1:4];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_pix   <= '0;
            r_col   <= '0;
            r_flip  <= 1'b0;
            r_k     <= 2'd0;
            r_coll  <= 1'b0;
        end else begin
            if (coll_clr) begin
                r_coll <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (seg_valid) begin
                        r_x     <= seg_x;
                        r_pix   <= seg_pix;
                        r_col   <= seg_col;
                        r_flip  <= seg_flip;
                        r_k     <= 2'd0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_nib != 4'd0) begin
                        r_state <= S_CHECK;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                S_CHECK: begin
                    // A collision in the same cycle as coll_clr keeps the flag set.
                    if (!w_slot_free) begin
                        r_coll <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_k     <= r_k + 2'd1;
                        r_state <= S_ADDR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign seg_ready = !reset && (r_state == S_IDLE);
    assign lb_wadr   = r_x + XW'(r_k);
    assign lb_wdat   = {r_col, w_nib};
    assign lb_we     = !reset && (r_state == S_CHECK) && w_slot_free;
    assign coll_flag = r_coll;

endmodule

// File: tb/tb_sprite_line_writer.sv
// Directed bench for sprite_line_writer with a behavioural line buffer (registered read port).
module tb_sprite_line_writer;

    logic        clk;
    logic        reset;
    logic        seg_valid;
    logic        seg_ready;
    logic [9:0]  seg_x;
    logic [15:0] seg_pix;
    logic [6:0]  seg_col;
    logic        seg_flip;
    logic [9:0]  lb_wadr;
    logic [10:0] lb_wdat;
    logic        lb_we;
    logic [10:0] lb_rdat1;
    logic        coll_clr;
    logic        coll_flag;

    logic [10:0] mem [0:1023];
    logic        mem_clr;
    logic        pl_en;
    logic [9:0]  pl_adr;
    logic [10:0] pl_dat;
    int          wr_cnt;

    int n_checks;
    int n_fail;

    sprite_line_writer #(.XW(10), .COLW(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_x     (seg_x),
        .seg_pix   (seg_pix),
        .seg_col   (seg_col),
        .seg_flip  (seg_flip),
        .lb_wadr   (lb_wadr),
        .lb_wdat   (lb_wdat),
        .lb_we     (lb_we),
        .lb_rdat1  (lb_rdat1),
        .coll_clr  (coll_clr),
        .coll_flag (coll_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer model: write port plus read data registered one cycle after the address.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 11'h000;
            wr_cnt <= 0;
        end else begin
            if (pl_en) mem[pl_adr] <= pl_dat;
            if (lb_we) begin
                mem[lb_wadr] <= lb_wdat;
                wr_cnt <= wr_cnt + 1;
            end
        end
        lb_rdat1 <= mem[lb_wadr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_buf();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic preload(input logic [9:0] adr, input logic [10:0] dat);
        pl_en  = 1'b1;
        pl_adr = adr;
        pl_dat = dat;
        tick();
        pl_en  = 1'b0;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic send(input logic [9:0] x, input logic [15:0] pix, input logic [6:0] col,
                        input logic flip);
        int n;
        n = 0;
        while (!seg_ready && n < 100) begin
            tick();
            n++;
        end
        if (!seg_ready) chk("send_timeout", 32'd0, 32'd1);
        seg_valid = 1'b1;
        seg_x     = x;
        seg_pix   = pix;
        seg_col   = col;
        seg_flip  = flip;
        tick();
        seg_valid = 1'b0;
        seg_x     = 10'h3FF;
        seg_pix   = 16'hFFFF;
        seg_col   = 7'h7F;
        seg_flip  = ~flip;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!seg_ready && n < 100) begin
            tick();
            n++;
        end
        if (!seg_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int w0;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        seg_valid = 1'b0;
        seg_x     = '0;
        seg_pix   = '0;
        seg_col   = '0;
        seg_flip  = 1'b0;
        coll_clr  = 1'b0;
        mem_clr   = 1'b0;
        pl_en     = 1'b0;
        pl_adr    = '0;
        pl_dat    = '0;
        tick();
        clear_buf();
        chk("rst_ready", 32'(seg_ready), 32'd0);
        chk("rst_we",    32'(lb_we),     32'd0);
        chk("rst_wadr",  32'(lb_wadr),   32'd0);
        chk("rst_wdat",  32'(lb_wdat),   32'd0);
        chk("rst_coll",  32'(coll_flag), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(seg_ready), 32'd1);

        // 1: plain segment, last pixel transparent; per-cycle bus trace
        send(10'd16, 16'h1230, 7'd5, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t1_we_c%0d", c), 32'(lb_we), 32'((c == 2) || (c == 4) || (c == 6)));
            if (c == 2) chk("t1_adr_c2", 32'(lb_wadr), 32'd16);
            if (c == 4) chk("t1_adr_c4", 32'(lb_wadr), 32'd17);
            if (c == 6) chk("t1_adr_c6", 32'(lb_wadr), 32'd18);
            chk($sformatf("t1_rdy_c%0d", c), 32'(seg_ready), 32'(c == 8));
            if (c < 8) tick();
        end
        chk("t1_m16", 32'(mem[16]), 32'h051);
        chk("t1_m17", 32'(mem[17]), 32'h052);
        chk("t1_m18", 32'(mem[18]), 32'h053);
        chk("t1_m19", 32'(mem[19]), 32'h000);
        chk("t1_wrs", 32'(wr_cnt),  32'd3);
        chk("t1_coll", 32'(coll_flag), 32'd0);

        // 2: same segment flipped
        clear_buf();
        send(10'd16, 16'h1230, 7'd5, 1'b1);
        wait_idle(n);
        chk("t2_lat", 32'(n), 32'd7);
        chk("t2_m16", 32'(mem[16]), 32'h000);
        chk("t2_m17", 32'(mem[17]), 32'h053);
        chk("t2_m18", 32'(mem[18]), 32'h052);
        chk("t2_m19", 32'(mem[19]), 32'h051);

        // 3: opaque pixel already in the buffer wins and raises the flag
        clear_buf();
        preload(10'd17, 11'h00A);
        send(10'd16, 16'h1230, 7'd5, 1'b0);
        wait_idle(n);
        chk("t3_m16", 32'(mem[16]), 32'h051);
        chk("t3_m17", 32'(mem[17]), 32'h00A);
        chk("t3_m18", 32'(mem[18]), 32'h053);
        chk("t3_wrs", 32'(wr_cnt),  32'd2);
        chk("t3_coll", 32'(coll_flag), 32'd1);
        coll_clr = 1'b1;
        tick();
        coll_clr = 1'b0;
        chk("t3_clr", 32'(coll_flag), 32'd0);

        // 4: address wrap, all opaque
        clear_buf();
        send(10'd1022, 16'h1111, 7'd3, 1'b0);
        wait_idle(n);
        chk("t4_lat",  32'(n), 32'd8);
        chk("t4_m1022", 32'(mem[1022]), 32'h031);
        chk("t4_m1023", 32'(mem[1023]), 32'h031);
        chk("t4_m0",   32'(mem[0]), 32'h031);
        chk("t4_m1",   32'(mem[1]), 32'h031);
        chk("t4_wrs",  32'(wr_cnt), 32'd4);

        // 5: overlapping segments back-to-back
        clear_buf();
        send(10'd8, 16'h1234, 7'd1, 1'b0);
        send(10'd10, 16'h5678, 7'd2, 1'b0);
        wait_idle(n);
        chk("t5_m8",  32'(mem[8]),  32'h011);
        chk("t5_m9",  32'(mem[9]),  32'h012);
        chk("t5_m10", 32'(mem[10]), 32'h013);
        chk("t5_m11", 32'(mem[11]), 32'h014);
        chk("t5_m12", 32'(mem[12]), 32'h027);
        chk("t5_m13", 32'(mem[13]), 32'h028);
        chk("t5_wrs", 32'(wr_cnt),  32'd6);
        chk("t5_coll", 32'(coll_flag), 32'd1);

        // 6: reset during the second CHECK abandons the segment
        clear_buf();
        send(10'd16, 16'h1234, 7'd5, 1'b0);
        tick();
        tick();
        tick();
        chk("t6_we_pre", 32'(lb_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_we_rst", 32'(lb_we), 32'd0);
        tick();
        chk("t6_rdy_rst", 32'(seg_ready), 32'd0);
        chk("t6_coll_rst", 32'(coll_flag), 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_rdy_rel", 32'(seg_ready), 32'd1);
        w0 = wr_cnt;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("t6_we_post%0d", c), 32'(lb_we), 32'd0);
            tick();
        end
        chk("t6_wrs", 32'(wr_cnt - w0), 32'd0);
        chk("t6_m16", 32'(mem[16]), 32'h051);
        chk("t6_m17", 32'(mem[17]), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
